// File: rtl/blit_read_unit.sv
// Blitter source fetch: byte reads, in-order responses paired with queued dst.
// Optional solid-fill path is built when BLIT_READ_FILL_EN is defined.
`timescale 1ns/1ps
module blit_read_unit #(
  parameter int MAX_OUT = 4,
  parameter int ADDR_W  = 26
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] p2_src_addr,
  input  logic [ADDR_W-1:0] p2_dst_addr,
  input  logic              p2_valid,
  output logic              p2_ready,
`ifdef BLIT_READ_FILL_EN
  input  logic              fill_mode,
  input  logic [7:0]        fill_color,
`endif
  input  logic              abort,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] p3_addr,
  output logic [7:0]        p3_data,
  output logic              p3_write,
  output logic              p3_idle,
  output logic              err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [1:0]        lane;
  } ent_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [CW-1:0] wp, rp;
  ent_t          fifo [MAX_OUT];
  ent_t          head;
  logic          run, rv_ok, room;
  logic          issue, pop, fill_acc;
  logic [7:0]    lane_byte, fill_px;

  assign run   = state == RUN;
  assign rv_ok = mem_rvalid && count != '0;
  assign room  = (count < CW'(MAX_OUT)) || mem_rvalid;

`ifdef BLIT_READ_FILL_EN
  logic fill_ok;
  assign fill_ok  = run && !abort && count == '0 && !mem_rvalid;
  assign mem_req  = p2_valid && !fill_mode && room && run && !abort;
  assign p2_ready = fill_mode ? fill_ok
                  : (mem_ready && room && run && !abort);
  assign fill_acc = fill_mode && p2_valid && fill_ok;
  assign fill_px  = fill_color;
`else
  assign mem_req  = p2_valid && room && run && !abort;
  assign p2_ready = mem_ready && room && run && !abort;
  assign fill_acc = 1'b0;
  assign fill_px  = 8'h00;
`endif

  assign mem_addr  = {p2_src_addr[ADDR_W-1:2], 2'b00};
  assign issue     = mem_req && mem_ready;
  assign pop       = rv_ok && run && !abort;
  assign head      = fifo[rp[PW-1:0]];
  assign lane_byte = mem_rdata[{head.lane, 3'b000} +: 8];
  assign count_nx  = count + CW'(issue) - CW'(rv_ok);

  always_comb begin
    state_nx = state;
    case (state)
      RUN:   if (abort && count_nx != '0) state_nx = DRAIN;
      DRAIN: if (count_nx == '0) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock)
    if (issue)
      fifo[wp[PW-1:0]] <= '{dst: p2_dst_addr, lane: p2_src_addr[1:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      count <= '0;
      wp    <= '0;
      rp    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      err   <= err | (mem_rvalid && count == '0);
      // abort cancels everything queued; responses still owed are drained
      if (run && abort) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (issue) wp <= wp + 1'b1;
        if (pop)   rp <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p3_write <= 1'b0;
      p3_addr  <= '0;
      p3_data  <= '0;
      p3_idle  <= 1'b1;
    end else begin
      p3_write <= pop || fill_acc;
      p3_idle  <= run && count_nx == '0 && !p2_valid;
      if (pop) begin
        p3_addr <= head.dst;
        p3_data <= lane_byte;
      end else if (fill_acc) begin
        p3_addr <= p2_dst_addr;
        p3_data <= fill_px;
      end
    end
  end

endmodule

// File: tb/tb_blit_read_unit.sv
// Bench for blit_read_unit: in-order memory model plus expected-pixel queue.
`timescale 1ns/1ps
module tb_blit_read_unit;
  localparam int AW = 26;
  localparam int MO = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } px_t;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] p2_src_addr = '0;
  logic [AW-1:0] p2_dst_addr = '0;
  logic          p2_valid = 1'b0;
  logic          abort = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          fill_mode = 1'b0;
  logic [7:0]    fill_color = '0;
  logic          p2_ready, mem_req, p3_write, p3_idle, err;
  logic [AW-1:0] mem_addr, p3_addr;
  logic [7:0]    p3_data;

  blit_read_unit #(.MAX_OUT(MO), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn),
    .p2_src_addr(p2_src_addr), .p2_dst_addr(p2_dst_addr),
    .p2_valid(p2_valid), .p2_ready(p2_ready),
`ifdef BLIT_READ_FILL_EN
    .fill_mode(fill_mode), .fill_color(fill_color),
`endif
    .abort(abort), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .p3_addr(p3_addr), .p3_data(p3_data),
    .p3_write(p3_write), .p3_idle(p3_idle), .err(err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int outst = 0;
  int acc_n = 0;
  bit auto_mem = 1'b0;
  px_t expq[$];
  logic [AW-1:0] pend[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memword(input logic [AW-1:0] a);
    if (a == 26'h104) return 32'hDDCCBBAA;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [7:0] srcbyte(input logic [AW-1:0] s);
    logic [31:0] w;
    w = memword({s[AW-1:2], 2'b00});
    return 8'(w >> (8 * s[1:0]));
  endfunction

  task automatic observe();
    px_t e;
    logic acc;
    if (p3_write) begin
      if (expq.size() == 0) begin
        chk("p3_spurious", 32'(p3_write), 32'h0);
      end else begin
        e = expq.pop_front();
        chk("p3_addr", 32'(p3_addr), 32'(e.a));
        chk("p3_data", 32'(p3_data), 32'(e.d));
      end
    end
    if (abort) expq.delete();
    acc = p2_valid && p2_ready;
    if (acc) begin
      acc_n++;
      if (fill_mode)
        expq.push_back('{a: p2_dst_addr, d: fill_color});
      else
        expq.push_back('{a: p2_dst_addr, d: srcbyte(p2_src_addr)});
    end
    if (mem_req || acc)
      chk("issue_vs_accept", 32'(mem_req && mem_ready),
          32'(acc && !fill_mode));
    if (mem_req && mem_ready) begin
      chk("mem_addr", 32'(mem_addr), 32'({p2_src_addr[AW-1:2], 2'b00}));
      pend.push_back(mem_addr);
      outst++;
    end
    if (mem_rvalid && outst > 0) outst--;
    if (mem_req && mem_ready) chk("outstanding_le_max", 32'(outst <= MO), 32'h1);
  endtask

  task automatic tick();
    @(negedge clock);
    observe();
    @(posedge clock);
    #2;
    if (auto_mem) begin
      mem_rvalid = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memword(pend.pop_front());
      end
    end
  endtask

  task automatic respond();
    mem_rvalid = 1'b1;
    mem_rdata  = memword(pend.pop_front());
  endtask

  task automatic drain(input string tag);
    int k;
    p2_valid  = 1'b0;
    fill_mode = 1'b0;
    mem_ready = 1'b1;
    auto_mem  = 1'b1;
    for (k = 0; k < 300 && (expq.size() > 0 || pend.size() > 0); k++) tick();
    chk(tag, 32'(expq.size() + pend.size()), 32'h0);
    tick();
    auto_mem   = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic rand_req();
    p2_src_addr = AW'($urandom());
    p2_dst_addr = AW'($urandom());
  endtask

  initial begin
    logic [AW-1:0] s_q [6];
    logic [AW-1:0] d_q [6];
    int i;
    int a0;

    repeat (2) @(posedge clock);
    #2;
    chk("rst_idle", 32'(p3_idle), 32'h1);
    chk("rst_write", 32'(p3_write), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_ready", 32'(p2_ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    resetn = 1'b1;
    @(posedge clock);
    #2;

    mem_ready   = 1'b1;
    p2_src_addr = 26'h000105;
    p2_dst_addr = 26'h200000;
    p2_valid    = 1'b1;
    #1;
    chk("single_req", 32'(mem_req), 32'h1);
    chk("single_maddr", 32'(mem_addr), 32'h104);
    tick();
    p2_valid = 1'b0;
    tick();
    respond();
    tick();
    mem_rvalid = 1'b0;
    chk("single_write", 32'(p3_write), 32'h1);
    chk("single_data", 32'(p3_data), 32'hBB);
    chk("single_addr", 32'(p3_addr), 32'h200000);
    chk("single_idle", 32'(p3_idle), 32'h1);
    tick();
    chk("single_strobe", 32'(p3_write), 32'h0);

    for (int k = 0; k < 6; k++) begin
      s_q[k] = AW'($urandom());
      d_q[k] = AW'($urandom());
    end
    i = 0;
    for (int c = 0; c < 12; c++) begin
      p2_valid    = i < 6;
      p2_src_addr = s_q[i % 6];
      p2_dst_addr = d_q[i % 6];
      a0 = acc_n;
      tick();
      if (acc_n != a0) i++;
    end
    chk("bp_issued", 32'(i), 32'h4);
    chk("bp_ready_low", 32'(p2_ready), 32'h0);
    respond();
    #1;
    chk("full_pp_ready", 32'(p2_ready), 32'h1);
    chk("full_pp_req", 32'(mem_req), 32'h1);
    a0 = acc_n;
    tick();
    if (acc_n != a0) i++;
    chk("full_pp_acc", 32'(acc_n - a0), 32'h1);
    mem_rvalid = 1'b0;
    p2_src_addr = s_q[i % 6];
    p2_dst_addr = d_q[i % 6];
    #1;
    chk("full_pp_outst", 32'(outst), 32'h4);
    chk("full_pp_stall", 32'(p2_ready), 32'h0);
    auto_mem = 1'b1;
    for (int c = 0; c < 200 && i < 6; c++) begin
      p2_valid    = 1'b1;
      p2_src_addr = s_q[i];
      p2_dst_addr = d_q[i];
      a0 = acc_n;
      tick();
      if (acc_n != a0) i++;
    end
    chk("bp_all_accepted", 32'(i), 32'h6);
    drain("bp_drain");

    for (int k = 0; k < 3; k++) begin
      p2_valid = 1'b1;
      rand_req();
      tick();
    end
    p2_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    p2_valid = 1'b1;
    rand_req();
    #1;
    chk("drain_ready", 32'(p2_ready), 32'h0);
    chk("drain_req", 32'(mem_req), 32'h0);
    chk("drain_outst", 32'(outst), 32'h3);
    for (int k = 0; k < 3; k++) begin
      respond();
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("rerun_ready", 32'(p2_ready), 32'h1);
    tick();
    drain("abort_new_read");

    chk("err_before", 32'(err), 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom();
    tick();
    mem_rvalid = 1'b0;
    chk("stray_err", 32'(err), 32'h1);
    chk("stray_write", 32'(p3_write), 32'h0);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'h1);

`ifdef BLIT_READ_FILL_EN
    fill_mode   = 1'b1;
    fill_color  = 8'h3C;
    p2_dst_addr = 26'h10;
    p2_valid    = 1'b1;
    mem_ready   = 1'b0;
    #1;
    chk("fill_req", 32'(mem_req), 32'h0);
    chk("fill_ready", 32'(p2_ready), 32'h1);
    tick();
    p2_valid  = 1'b0;
    fill_mode = 1'b0;
    chk("fill_write", 32'(p3_write), 32'h1);
    chk("fill_data", 32'(p3_data), 32'h3C);
    chk("fill_addr", 32'(p3_addr), 32'h10);
    tick();
`endif

    auto_mem = 1'b1;
    for (int c = 0; c < 500; c++) begin
      p2_valid  = $urandom_range(0, 3) != 0;
      mem_ready = $urandom_range(0, 3) != 0;
      rand_req();
`ifdef BLIT_READ_FILL_EN
      fill_mode  = $urandom_range(0, 7) == 0;
      fill_color = 8'($urandom());
`endif
      tick();
    end
    drain("rand_drain");
    tick();
    chk("final_idle", 32'(p3_idle), 32'h1);
    chk("final_err", 32'(err), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
